// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with a small prefetch queue.
// Issues one word fetch at a time to instruction memory, buffers returned
// words with their PCs, and presents the oldest one to decode. A redirect
// flushes the queue and restarts fetching at the new target; a request that
// is still outstanding at redirect time is drained and its data dropped.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req, imem_addr     registered fetch request / word address
//   imem_ack, imem_rdata    memory completion and instruction word
//   redirect, redirect_pc   taken-control-flow pulse and new target
//   ir_valid, IR, ir_pc     queue head: valid, instruction, PC
//   ir_ready                decode accepts the head this cycle
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    input  logic        ir_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               imem_req_q, imem_req_d;
    logic [31:0]        imem_addr_q, imem_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;

    logic [31:0]        pc_mem    [DEPTH];
    logic [31:0]        instr_mem [DEPTH];

    logic               push_c;
    logic               pop_c;
    logic [31:0]        target_c;
    logic [31:0]        pc_plus4_c;
    logic [CNT_W-1:0]   count_pop_c;

    // Circular pointer increment that also handles non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign target_c    = redirect_pc & WORD_MASK;
    assign pc_plus4_c  = fetch_pc_q + 32'd4;
    assign pop_c       = (count_q != '0) && ir_ready && !redirect;
    assign count_pop_c = count_q - CNT_W'(pop_c);

    // Fetch control: in FETCH, fetch_pc_q is the outstanding address; in
    // IDLE and DRAIN it is the address to issue next.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        push_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    state_d     = FETCH;
                    fetch_pc_d  = target_c;
                    imem_req_d  = 1'b1;
                    imem_addr_d = target_c;
                end else if (count_pop_c < CNT_W'(DEPTH)) begin
                    state_d     = FETCH;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fetch_pc_d  = target_c;
                        imem_addr_d = target_c;
                    end else begin
                        push_c     = 1'b1;
                        fetch_pc_d = pc_plus4_c;
                        if (CNT_W'(count_pop_c + CNT_W'(1)) < CNT_W'(DEPTH)) begin
                            imem_addr_d = pc_plus4_c;
                        end else begin
                            state_d    = IDLE;
                            imem_req_d = 1'b0;
                        end
                    end
                end else if (redirect) begin
                    // Request stays on the bus at the old address until acked.
                    state_d    = DRAIN;
                    fetch_pc_d = target_c;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = target_c;
                end
                if (imem_ack) begin
                    state_d     = FETCH;
                    imem_addr_d = redirect ? target_c : fetch_pc_q;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Queue occupancy and pointers; redirect flushes everything.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (redirect) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            count_d = CNT_W'(count_pop_c + CNT_W'(push_c));
            if (pop_c) begin
                head_d = ptr_inc(head_q);
            end
            if (push_c) begin
                tail_d = ptr_inc(tail_q);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC & WORD_MASK;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    // Queue storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem[tail_q]    <= fetch_pc_q;
            instr_mem[tail_q] <= imem_rdata;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign ir_valid  = (count_q != '0);
    assign IR        = ir_valid ? instr_mem[head_q] : '0;
    assign ir_pc     = ir_valid ? pc_mem[head_q] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue: reset, streaming fetch, queue
// full back-pressure, redirect with drain, redirect coinciding with ack,
// repeated redirects during drain, PC wrap and reset mid-request.
module tb_instr_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic [31:0] IR;
    logic [31:0] ir_pc;
    logic        ir_ready;

    logic        ack_en;
    int          vectors;
    int          miscompares;

    instr_fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir_valid    (ir_valid),
        .IR          (IR),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack in the first request cycle when enabled.
    task automatic auto_resp();
        if (ack_en) begin
            imem_ack   = imem_req;
            imem_rdata = imem_addr ^ KEY;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
        end
    endtask

    // One rising edge; outputs are then sampled on the falling edge.
    task automatic clk_edge();
        @(posedge clk);
        @(negedge clk);
        redirect = 1'b0;
        auto_resp();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ir_ready    = 1'b0;
        ack_en      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_req: got req=%b addr=%h, expected req=0 addr=0", imem_req, imem_addr);
        end
        vectors++;
        if ({ir_valid, IR, ir_pc} !== {1'b0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_ir: got v=%b IR=%h pc=%h, expected all 0", ir_valid, IR, ir_pc);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_first_fetch: got req=%b addr=%h v=%b, expected req=1 addr=0 v=0",
                     imem_req, imem_addr, ir_valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        ir_ready = 1'b1;
        ack_en   = 1'b1;
        auto_resp();
        for (int k = 0; k < 8; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(4 * k);
            clk_edge();
            vectors++;
            if ({ir_valid, ir_pc, IR} !== {1'b1, exp_pc, exp_pc ^ KEY}) begin
                miscompares++;
                $display("FAIL stream_%0d: got v=%b pc=%h IR=%h, expected v=1 pc=%h IR=%h",
                         k, ir_valid, ir_pc, IR, exp_pc, exp_pc ^ KEY);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        ack_en = 1'b1;
        auto_resp();
        clk_edge();
        clk_edge();
        clk_edge();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin
            miscompares++;
            $display("FAIL full_third: got req=%b addr=%h, expected req=1 addr=c", imem_req, imem_addr);
        end
        clk_edge();
        vectors++;
        if ({imem_req, ir_valid, ir_pc, IR} !== {1'b0, 1'b1, 32'h0, KEY}) begin
            miscompares++;
            $display("FAIL full_stop: got req=%b v=%b pc=%h IR=%h, expected req=0 v=1 pc=0 IR=%h",
                     imem_req, ir_valid, ir_pc, IR, KEY);
        end
        clk_edge();
        clk_edge();
        vectors++;
        if ({imem_req, ir_pc} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL full_hold: got req=%b pc=%h, expected req=0 pc=0", imem_req, ir_pc);
        end
        ir_ready = 1'b1;
        clk_edge();
        ir_ready = 1'b0;
        ack_en   = 1'b0;
        auto_resp();
        vectors++;
        if ({ir_pc, imem_req, imem_addr} !== {32'h4, 1'b1, 32'h10}) begin
            miscompares++;
            $display("FAIL full_pop: got pc=%h req=%b addr=%h, expected pc=4 req=1 addr=10",
                     ir_pc, imem_req, imem_addr);
        end
        clk_edge();
        vectors++;
        if ({ir_pc, imem_req, imem_addr} !== {32'h4, 1'b1, 32'h10}) begin
            miscompares++;
            $display("FAIL full_stable: got pc=%h req=%b addr=%h, expected pc=4 req=1 addr=10",
                     ir_pc, imem_req, imem_addr);
        end
    endtask

    task automatic test_drain();
        do_reset();
        ack_en = 1'b1;
        auto_resp();
        clk_edge();
        clk_edge();
        ack_en = 1'b0;
        auto_resp();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        clk_edge();
        vectors++;
        if ({ir_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin
            miscompares++;
            $display("FAIL drain_enter: got v=%b req=%b addr=%h, expected v=0 req=1 addr=8",
                     ir_valid, imem_req, imem_addr);
        end
        clk_edge();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        clk_edge();
        vectors++;
        if ({ir_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            miscompares++;
            $display("FAIL drain_discard: got v=%b req=%b addr=%h, expected v=0 req=1 addr=100",
                     ir_valid, imem_req, imem_addr);
        end
        ack_en = 1'b1;
        auto_resp();
        clk_edge();
        vectors++;
        if ({ir_valid, ir_pc, IR} !== {1'b1, 32'h100, 32'h100 ^ KEY}) begin
            miscompares++;
            $display("FAIL drain_first_ir: got v=%b pc=%h IR=%h, expected v=1 pc=100 IR=%h",
                     ir_valid, ir_pc, IR, 32'h100 ^ KEY);
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        ir_ready = 1'b1;
        ack_en   = 1'b1;
        auto_resp();
        clk_edge();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        clk_edge();
        vectors++;
        if ({ir_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
            miscompares++;
            $display("FAIL redir_ack_flush: got v=%b req=%b addr=%h, expected v=0 req=1 addr=40",
                     ir_valid, imem_req, imem_addr);
        end
        clk_edge();
        vectors++;
        if ({ir_valid, ir_pc, IR} !== {1'b1, 32'h40, 32'h40 ^ KEY}) begin
            miscompares++;
            $display("FAIL redir_ack_ir: got v=%b pc=%h IR=%h, expected v=1 pc=40 IR=%h",
                     ir_valid, ir_pc, IR, 32'h40 ^ KEY);
        end
    endtask

    task automatic test_double_redirect();
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        clk_edge();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        clk_edge();
        vectors++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL dbl_hold: got req=%b addr=%h v=%b, expected req=1 addr=0 v=0",
                     imem_req, imem_addr, ir_valid);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        clk_edge();
        vectors++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h300, 1'b0}) begin
            miscompares++;
            $display("FAIL dbl_target: got req=%b addr=%h v=%b, expected req=1 addr=300 v=0",
                     imem_req, imem_addr, ir_valid);
        end
        ack_en = 1'b1;
        auto_resp();
        clk_edge();
        vectors++;
        if ({ir_valid, ir_pc} !== {1'b1, 32'h300}) begin
            miscompares++;
            $display("FAIL dbl_ir: got v=%b pc=%h, expected v=1 pc=300", ir_valid, ir_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ack_en = 1'b1;
        auto_resp();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        clk_edge();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            miscompares++;
            $display("FAIL wrap_target: got req=%b addr=%h, expected req=1 addr=fffffffc",
                     imem_req, imem_addr);
        end
        clk_edge();
        vectors++;
        if ({ir_valid, ir_pc, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            miscompares++;
            $display("FAIL wrap_next: got v=%b pc=%h addr=%h, expected v=1 pc=fffffffc addr=0",
                     ir_valid, ir_pc, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_en = 1'b1;
        auto_resp();
        clk_edge();
        clk_edge();
        clk_edge();
        vectors++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'hC, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_setup: got req=%b addr=%h v=%b, expected req=1 addr=c v=1",
                     imem_req, imem_addr, ir_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({imem_req, imem_addr, ir_valid, IR, ir_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL mid_async: got req=%b addr=%h v=%b IR=%h pc=%h, expected all 0",
                     imem_req, imem_addr, ir_valid, IR, ir_pc);
        end
        ack_en     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        vectors++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_restart: got req=%b addr=%h v=%b, expected req=1 addr=0 v=0",
                     imem_req, imem_addr, ir_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        ack_en      = 1'b0;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ir_ready    = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_drain();
        test_redirect_ack();
        test_double_redirect();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries; legal values 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port imem_req  output  1  registered fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  32  registered word address of the outstanding request; bits [1:0] always 0.
REQ-007 SHALL have port imem_ack  input  1  memory completion; valid only while imem_req=1; may arrive in the first request cycle.
REQ-008 SHALL have port imem_rdata  input  32  instruction word; sampled only when imem_ack=1.
REQ-009 SHALL have port redirect  input  1  one-cycle pulse from execute on a taken branch, jump, ecall or uret.
REQ-010 SHALL have port redirect_pc  input  32  new fetch target; bits [1:0] ignored and treated as 0.
REQ-011 SHALL have port ir_valid  output  1  queue head holds an instruction.
REQ-012 SHALL have port IR  output  32  queue-head instruction word, fed to the decode controller.
REQ-013 SHALL have port ir_pc  output  32  PC of the queue-head instruction.
REQ-014 SHALL have port ir_ready  input  1  decode accepts the head this cycle.

Function
REQ-015 SHALL implement a FIFO of DEPTH entries {pc, instr} with occupancy count 0..DEPTH; ir_valid = (count != 0); IR and ir_pc SHALL be driven from the head entry with no added latency.
REQ-016 SHALL pop the head on a cycle where ir_valid=1, ir_ready=1 and redirect=0; the next entry SHALL appear at the outputs in the following cycle.
REQ-017 SHALL implement three states: IDLE (imem_req=0), FETCH (imem_req=1, imem_addr=fetch_pc) and DRAIN (imem_req=1, imem_data to be discarded).
REQ-018 IDLE: SHALL go to FETCH when the next-cycle count < DEPTH and redirect=0.
REQ-019 FETCH with imem_ack=1 and redirect=0: SHALL push {fetch_pc, imem_rdata} and advance fetch_pc by 4, wrapping modulo 2^32; SHALL stay in FETCH if post-update count < DEPTH, else go to IDLE.
REQ-020 FETCH with imem_ack=0: imem_req and imem_addr SHALL stay stable until ack.
REQ-021 A simultaneous push and pop SHALL leave count unchanged; a push SHALL never occur when count = DEPTH.
REQ-022 On redirect=1, the queue SHALL flush (count=0, ir_valid=0 next cycle) and fetch_pc SHALL become {redirect_pc[31:2],2'b00}; any pop or push that cycle SHALL be dropped.
REQ-023 Redirect in FETCH with imem_ack=1, or in IDLE: SHALL go to FETCH and issue redirect_pc in the next cycle.
REQ-024 Redirect in FETCH with imem_ack=0: SHALL go to DRAIN, keeping imem_addr at the old address until ack.
REQ-025 DRAIN on imem_ack: SHALL discard imem_rdata and go to FETCH at the latest redirect target; a further redirect during DRAIN SHALL replace the target, and the latest one SHALL win.
REQ-026 SHALL never have more than one outstanding memory request.

Reset
REQ-027 While rst_n=0: imem_req=0, imem_addr=0, count=0, ir_valid=0, IR=0, ir_pc=0, state=IDLE, fetch_pc=RESET_PC.
REQ-028 Reset asserted mid-request SHALL abandon the request immediately; an ack arriving after reset release with imem_req=0 SHALL be ignored.
REQ-029 The first clock edge after rst_n rises SHALL enter FETCH, with imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-030 Release reset, ack every request in its first cycle with rdata=addr^32'hA5A5A5A5, ir_ready=1 -> ir_pc sequence 0,4,8,C..., no gaps after the first instruction.
REQ-031 ir_ready=0, DEPTH=4 -> exactly 4 pushes (PCs 0..C), then imem_req=0; raising ir_ready for one cycle -> one pop, one new request at 0x10.
REQ-032 Redirect to 32'h0000_0103 while a request at 0x8 is unacked -> DRAIN; ack at 0x8 is discarded; next imem_addr=0x100; first IR after flush has ir_pc=0x100.
REQ-033 Redirect with imem_ack=1 in the same cycle -> that word is not pushed; ir_valid=0 next cycle; next request at the new target.
REQ-034 Two redirects (0x200, then 0x300) during one DRAIN -> only 0x300 is fetched.
REQ-035 Assert rst_n=0 while imem_req=1 and count=3 -> all outputs are 0 within the same cycle; after release, the first request is at RESET_PC.
